// File: rtl/stopwatch_display_pkg.sv
// Shared definitions for the stopwatch seven-segment display.
//   - Segment patterns (active-low, bit 7 = dp, bits 6:0 = g..a), dp off.
//   - Anode patterns (active-low), one per digit slot plus all-off.
//   - Digit-slot index type, in scan order.
//   - Helper that splits a 0..63 binary value into tens/ones or a dash flag.
package stopwatch_display_pkg;

    localparam logic [7:0] SEG_0    = 8'hC0;
    localparam logic [7:0] SEG_1    = 8'hF9;
    localparam logic [7:0] SEG_2    = 8'hA4;
    localparam logic [7:0] SEG_3    = 8'hB0;
    localparam logic [7:0] SEG_4    = 8'h99;
    localparam logic [7:0] SEG_5    = 8'h92;
    localparam logic [7:0] SEG_6    = 8'h82;
    localparam logic [7:0] SEG_7    = 8'hF8;
    localparam logic [7:0] SEG_8    = 8'h80;
    localparam logic [7:0] SEG_9    = 8'h90;
    localparam logic [7:0] SEG_DASH = 8'hBF;
    localparam logic [7:0] SEG_OFF  = 8'hFF;

    localparam logic [3:0] AN_OFF      = 4'b1111;
    localparam logic [3:0] AN_SEC_ONES = 4'b1110;
    localparam logic [3:0] AN_SEC_TENS = 4'b1101;
    localparam logic [3:0] AN_MIN_ONES = 4'b1011;
    localparam logic [3:0] AN_MIN_TENS = 4'b0111;

    // Largest value that is shown as digits; anything above shows dashes.
    localparam logic [5:0] MAX_SHOWN = 6'd59;

    typedef enum logic [1:0] {
        DIG_SEC_ONES = 2'd0,
        DIG_SEC_TENS = 2'd1,
        DIG_MIN_ONES = 2'd2,
        DIG_MIN_TENS = 2'd3
    } digit_idx_t;

    typedef struct packed {
        logic       dash;
        logic [3:0] tens;
        logic [3:0] ones;
    } digit_pair_t;

    function automatic digit_pair_t split_value(input logic [5:0] v);
        digit_pair_t p;
        p.dash = (v > MAX_SHOWN);
        p.tens = 4'(v / 6'd10);
        p.ones = 4'(v % 6'd10);
        return p;
    endfunction

    function automatic logic [3:0] anode_for(input digit_idx_t d);
        logic [3:0] a;
        case (d)
            DIG_SEC_ONES: a = AN_SEC_ONES;
            DIG_SEC_TENS: a = AN_SEC_TENS;
            DIG_MIN_ONES: a = AN_MIN_ONES;
            DIG_MIN_TENS: a = AN_MIN_TENS;
            default:      a = AN_OFF;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/stopwatch_display_seg7_decoder.sv
// seg7_decoder: combinational BCD digit to active-low a..g segments.
//   digit : 4-bit value, 0..9 shown, 10..15 blank
//   dash  : 1 = show a dash (only segment g lit), overrides digit
//   seg   : active-low segments, seg[0]=a .. seg[6]=g
module seg7_decoder
    import stopwatch_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF[6:0];
        if (dash) begin
            seg = SEG_DASH[6:0];
        end else begin
            case (digit)
                4'd0:    seg = SEG_0[6:0];
                4'd1:    seg = SEG_1[6:0];
                4'd2:    seg = SEG_2[6:0];
                4'd3:    seg = SEG_3[6:0];
                4'd4:    seg = SEG_4[6:0];
                4'd5:    seg = SEG_5[6:0];
                4'd6:    seg = SEG_6[6:0];
                4'd7:    seg = SEG_7[6:0];
                4'd8:    seg = SEG_8[6:0];
                4'd9:    seg = SEG_9[6:0];
                default: seg = SEG_OFF[6:0];
            endcase
        end
    end

endmodule

// File: rtl/stopwatch_display.sv
// stopwatch_display: drives a 4-digit common-anode multiplexed display as MM.SS.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   seconds   : binary seconds 0..59 (60..63 shown as dashes)
//   minutes   : binary minutes 0..59 (60..63 shown as dashes)
//   blink_en  : 1 = blank the selected pair during the blink off phase
//   blink_sel : 0 = seconds pair, 1 = minutes pair
//   seg       : registered active-low segments, seg[7] = dp
//   an        : registered active-low anodes, an[3] = minutes tens .. an[0] = seconds ones
module stopwatch_display
    import stopwatch_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic       blink_en,
    input  logic       blink_sel,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam int unsigned RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [RW-1:0] ref_cnt;
    logic [BW-1:0] blink_cnt;
    logic          ref_tick;
    logic          blink_phase;
    digit_idx_t    d;
    logic [5:0]    cap_min;
    logic [5:0]    cap_sec;

    logic          show_min;
    logic          show_tens;
    logic [5:0]    pair_val;
    digit_pair_t   pair_digits;
    logic [3:0]    dec_digit;
    logic          dec_dash;
    logic [6:0]    dec_seg;
    logic          blank;

    assign ref_tick = (ref_cnt == REF_LAST);

    // Digit scan. Inputs are only sampled as the scan wraps back to slot 0,
    // so one full scan always shows a single coherent MM:SS value.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt <= '0;
            d       <= DIG_SEC_ONES;
            cap_min <= '0;
            cap_sec <= '0;
        end else if (ref_tick) begin
            ref_cnt <= '0;
            d       <= digit_idx_t'(d + 2'd1);
            if (d == DIG_MIN_TENS) begin
                cap_min <= minutes;
                cap_sec <= seconds;
            end
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    // Free-running blink timebase; blink_en only gates its effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        show_min    = (d == DIG_MIN_ONES) || (d == DIG_MIN_TENS);
        show_tens   = (d == DIG_SEC_TENS) || (d == DIG_MIN_TENS);
        pair_val    = show_min ? cap_min : cap_sec;
        pair_digits = split_value(pair_val);
        dec_digit   = show_tens ? pair_digits.tens : pair_digits.ones;
        dec_dash    = pair_digits.dash;
        blank       = blink_en && blink_phase && (blink_sel == show_min);
    end

    seg7_decoder u_dec (
        .digit (dec_digit),
        .dash  (dec_dash),
        .seg   (dec_seg)
    );

    // Blanked slots also drop segments so the dp can never appear without
    // its anode active.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else if (blank) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else begin
            an  <= anode_for(d);
            seg <= {(d != DIG_MIN_ONES), dec_seg};
        end
    end

endmodule

// File: tb/tb_stopwatch_display.sv
module tb_stopwatch_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] seconds = '0;
    logic [5:0] minutes = '0;
    logic       blink_en = 1'b0;
    logic       blink_sel = 1'b0;
    logic [7:0] seg;
    logic [3:0] an;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    localparam logic [3:0] AN_TAB   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    localparam logic [7:0] EXP_ZERO [4] = '{8'hC0, 8'hC0, 8'h40, 8'hC0};
    localparam logic [7:0] EXP_1234 [4] = '{8'h99, 8'hB0, 8'h24, 8'hF9};
    localparam logic [7:0] EXP_1235 [4] = '{8'h92, 8'hB0, 8'h24, 8'hF9};
    localparam logic [7:0] EXP_5959 [4] = '{8'h90, 8'h92, 8'h10, 8'h92};
    localparam logic [7:0] EXP_5960 [4] = '{8'hBF, 8'hBF, 8'h10, 8'h92};

    stopwatch_display #(.REFRESH_DIV(4), .BLINK_DIV(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .seconds   (seconds),
        .minutes   (minutes),
        .blink_en  (blink_en),
        .blink_sel (blink_sel),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = ~clk;

    // Advance one clock, sample 1 time unit after the edge, and check the
    // one-anode / dp-position invariants on every cycle.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (chk_on) begin
            checks++;
            if (($countones(~an) > 1) || (seg[7] === 1'b0 && an !== 4'b1011)) begin
                errors++;
                $display("FAIL invariant t=%0t an=%b seg=%h (need <=1 anode low, dp only with an=1011)",
                         $time, an, seg);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    function automatic int slot_of(input int c);
        return ((c - 1) / 4) % 4;
    endfunction

    function automatic int scan_of(input int c);
        return (c - 1) / 16;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step();
        chk_on = 1'b1;
        step();
        checks++;
        if (an !== 4'b1111 || seg !== 8'hFF) begin
            errors++;
            $display("FAIL reset_state an=%b seg=%h expected an=1111 seg=ff", an, seg);
        end
        rst = 1'b0;
        cyc = 0;
        step();
        checks++;
        if (an !== 4'b1110 || seg !== 8'hC0) begin
            errors++;
            $display("FAIL first_after_reset an=%b seg=%h expected an=1110 seg=c0", an, seg);
        end
    endtask

    task automatic test_scan();
        logic [7:0] e;
        int s;
        minutes = 6'd12; seconds = 6'd34; blink_en = 1'b0;
        do_reset();
        for (int i = 0; i < 48; i++) begin
            step();
            s = slot_of(cyc);
            e = (scan_of(cyc) == 0) ? EXP_ZERO[s] : EXP_1234[s];
            checks++;
            if (an !== AN_TAB[s] || seg !== e) begin
                errors++;
                $display("FAIL scan_1234 cyc=%0d an=%b seg=%h expected an=%b seg=%h",
                         cyc, an, seg, AN_TAB[s], e);
            end
        end
    endtask

    task automatic test_capture();
        logic [7:0] e;
        int s;
        minutes = 6'd12; seconds = 6'd34; blink_en = 1'b0;
        do_reset();
        repeat (21) step();
        seconds = 6'd35;
        for (int i = 0; i < 27; i++) begin
            step();
            s = slot_of(cyc);
            e = (scan_of(cyc) < 2) ? EXP_1234[s] : EXP_1235[s];
            checks++;
            if (an !== AN_TAB[s] || seg !== e) begin
                errors++;
                $display("FAIL capture_anti_tear cyc=%0d an=%b seg=%h expected an=%b seg=%h",
                         cyc, an, seg, AN_TAB[s], e);
            end
        end
    endtask

    task automatic test_range();
        logic [7:0] e;
        int s;
        minutes = 6'd59; seconds = 6'd59; blink_en = 1'b0;
        do_reset();
        repeat (16) step();
        for (int i = 0; i < 48; i++) begin
            step();
            if (cyc == 33) seconds = 6'd60;
            s = slot_of(cyc);
            e = (scan_of(cyc) < 3) ? EXP_5959[s] : EXP_5960[s];
            checks++;
            if (an !== AN_TAB[s] || seg !== e) begin
                errors++;
                $display("FAIL range_59_60 cyc=%0d an=%b seg=%h expected an=%b seg=%h",
                         cyc, an, seg, AN_TAB[s], e);
            end
        end
    endtask

    task automatic test_blink();
        logic [7:0] e;
        int s;
        bit blanked;
        minutes = 6'd12; seconds = 6'd34; blink_en = 1'b1; blink_sel = 1'b1;
        do_reset();
        for (int i = 0; i < 96; i++) begin
            step();
            s = slot_of(cyc);
            blanked = (cyc >= 33) && (cyc <= 64) && (s >= 2);
            e = (scan_of(cyc) == 0) ? EXP_ZERO[s] : EXP_1234[s];
            checks++;
            if (blanked) begin
                if (an !== 4'b1111) begin
                    errors++;
                    $display("FAIL blink_min_off cyc=%0d an=%b expected an=1111", cyc, an);
                end
            end else if (an !== AN_TAB[s] || seg !== e) begin
                errors++;
                $display("FAIL blink_min_on cyc=%0d an=%b seg=%h expected an=%b seg=%h",
                         cyc, an, seg, AN_TAB[s], e);
            end
        end
        // Phase goes off again from cycle 97 (slot 0); switch to seconds pair.
        blink_sel = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (an !== 4'b1111) begin
                errors++;
                $display("FAIL blink_sec_off cyc=%0d an=%b expected an=1111", cyc, an);
            end
        end
        blink_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (an !== 4'b1110 || seg !== 8'h99) begin
                errors++;
                $display("FAIL blink_disable cyc=%0d an=%b seg=%h expected an=1110 seg=99",
                         cyc, an, seg);
            end
        end
    endtask

    task automatic test_reset_mid();
        minutes = 6'd12; seconds = 6'd34; blink_en = 1'b0;
        do_reset();
        repeat (22) step();
        rst = 1'b1;
        step();
        checks++;
        if (an !== 4'b1111 || seg !== 8'hFF) begin
            errors++;
            $display("FAIL reset_mid_state an=%b seg=%h expected an=1111 seg=ff", an, seg);
        end
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (an !== AN_TAB[slot_of(cyc)] || seg !== EXP_ZERO[slot_of(cyc)]) begin
                errors++;
                $display("FAIL reset_mid_restart cyc=%0d an=%b seg=%h expected an=%b seg=%h",
                         cyc, an, seg, AN_TAB[slot_of(cyc)], EXP_ZERO[slot_of(cyc)]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_capture();
        test_range();
        test_blink();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
